// File: rtl/tx_redundant_framer_pkg.sv
// Shared constants, FSM state type and small helpers for the redundant-link transmit framer.
package tx_redundant_framer_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  localparam int PREAMBLE_LEN = 7;
  localparam int HEADER_LEN   = 14;
  localparam int FCS_LEN      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_FCS,
    ST_IFG
  } state_t;

  // A zero copy/segment count from the switches still means "send once".
  function automatic logic [7:0] sat_one(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

endpackage

// File: rtl/tx_redundant_framer_crc32_d8.sv
// Combinational next-state of the reflected IEEE CRC32 for one data byte.
module tx_redundant_framer_crc32_d8
  import tx_redundant_framer_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

  assign crc_next = crc_byte(crc, data);

endmodule

// File: rtl/tx_redundant_framer.sv
// Burst frame generator: each segment is sent `redundancy` times as a full GMII frame with FCS.
//  state       | meaning
//  ST_IDLE     | waiting for start
//  ST_PREAMBLE | 7 x 0x55
//  ST_SFD      | 0xD5, CRC preset
//  ST_HEADER   | frame index 0..13 (MACs, ethertype)
//  ST_PAYLOAD  | copy, segment and test pattern bytes
//  ST_FCS      | 4 bytes of ~crc, LSB byte first
//  ST_IFG      | idle gap, then next copy/segment or done
module tx_redundant_framer
  import tx_redundant_framer_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_00_01,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          PAYLOAD_LEN = 64,
  parameter int          IFG_LEN     = 12
) (
  input  logic       clk125MHz,
  input  logic       rst,
  input  logic       adv_data,
  input  logic       start,
  input  logic [7:0] redundancy,
  input  logic [7:0] segment_number_max,
  output logic [7:0] tx_data,
  output logic       tx_en,
  output logic       busy,
  output logic       done
);

  localparam logic [111:0] HDR       = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [10:0]  HDR_LAST  = 11'(HEADER_LEN - 1);
  localparam logic [10:0]  LAST_IDX  = 11'(HEADER_LEN + PAYLOAD_LEN - 1);
  localparam logic [7:0]  PRE_LAST   = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  FCS_LAST   = 8'(FCS_LEN - 1);
  localparam logic [7:0]  IFG_LAST   = 8'(IFG_LEN - 1);

  state_t      state;
  logic [7:0]  red_q, max_q, seg, copy, cnt;
  logic [10:0] idx;
  logic [31:0] crc, crc_next, crc_inv;
  logic [7:0]  hdr_byte, pay_byte, idx_byte, fcs_byte, pay_lo;

  always_comb begin
    hdr_byte = 8'd0;
    for (int i = 0; i < HEADER_LEN; i++)
      if (idx == 11'(i)) hdr_byte = HDR[111-8*i -: 8];
  end

  // Test pattern restarts at index 17 and is scrambled by the segment number.
  assign pay_lo = idx[7:0] - 8'd17;

  always_comb begin
    case (idx)
      11'd14:  pay_byte = copy;
      11'd15:  pay_byte = 8'd0;
      11'd16:  pay_byte = seg;
      default: pay_byte = pay_lo ^ seg;
    endcase
  end

  assign idx_byte = (state == ST_HEADER) ? hdr_byte : pay_byte;

  tx_redundant_framer_crc32_d8 u_crc (
    .crc      (crc),
    .data     (idx_byte),
    .crc_next (crc_next)
  );

  assign crc_inv = ~crc;

  always_comb begin
    case (cnt[1:0])
      2'd0:    fcs_byte = crc_inv[7:0];
      2'd1:    fcs_byte = crc_inv[15:8];
      2'd2:    fcs_byte = crc_inv[23:16];
      default: fcs_byte = crc_inv[31:24];
    endcase
  end

  always_ff @(posedge clk125MHz) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_data <= 8'd0;
      tx_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      red_q   <= 8'd0;
      max_q   <= 8'd0;
      seg     <= 8'd0;
      copy    <= 8'd0;
      cnt     <= 8'd0;
      idx     <= 11'd0;
      crc     <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A start in the same cycle as done belongs to the finished burst.
          if (start && !done) begin
            red_q <= sat_one(redundancy);
            max_q <= sat_one(segment_number_max);
            seg   <= 8'd0;
            copy  <= 8'd0;
            cnt   <= 8'd0;
            busy  <= 1'b1;
            state <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: if (adv_data) begin
          tx_en   <= 1'b1;
          tx_data <= PREAMBLE_BYTE;
          if (cnt == PRE_LAST) begin
            cnt   <= 8'd0;
            state <= ST_SFD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_SFD: if (adv_data) begin
          tx_data <= SFD_BYTE;
          idx     <= 11'd0;
          crc     <= CRC_INIT;
          state   <= ST_HEADER;
        end
        ST_HEADER: if (adv_data) begin
          tx_data <= idx_byte;
          crc     <= crc_next;
          idx     <= idx + 11'd1;
          if (idx == HDR_LAST) state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: if (adv_data) begin
          tx_data <= idx_byte;
          crc     <= crc_next;
          idx     <= idx + 11'd1;
          if (idx == LAST_IDX) begin
            cnt   <= 8'd0;
            state <= ST_FCS;
          end
        end
        ST_FCS: if (adv_data) begin
          tx_data <= fcs_byte;
          if (cnt == FCS_LAST) begin
            cnt   <= 8'd0;
            state <= ST_IFG;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_IFG: if (adv_data) begin
          tx_en   <= 1'b0;
          tx_data <= 8'd0;
          if (cnt == IFG_LAST) begin
            cnt <= 8'd0;
            if (copy != red_q - 8'd1) begin
              copy  <= copy + 8'd1;
              state <= ST_PREAMBLE;
            end else begin
              copy <= 8'd0;
              seg  <= seg + 8'd1;
              if (seg == max_q - 8'd1) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                state <= ST_PREAMBLE;
              end
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
